// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared shifter datapath constants, opcodes and instruction field layout
package datapath_pkg;

    localparam int WIDTH  = 16;
    localparam int REGS   = 8;
    localparam int ADDR_W = 3;
    localparam int AMT_W  = 4;
    localparam int OP_W   = 3;

    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RA_LSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int AMT_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        OP_SRL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_ROL = 3'b011,
        OP_SRA = 3'b100
    } shift_op_e;

    // Encodings above OP_SRA have no shifter function.
    function automatic logic isLegalOp(input logic [OP_W-1:0] op);
        return op <= OP_SRA;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - instruction, write-back and shifter-slot signals of the operand-fetch stage
interface operand_fetch_if;
    import datapath_pkg::*;

    logic                 InstrValid;
    logic [WIDTH-1:0]     Instr;
    logic                 InstrReady;
    logic                 WriteEnable;
    logic [ADDR_W-1:0]    WriteAddr;
    logic [WIDTH-1:0]     WriteData;
    logic                 OutValid;
    logic                 OutReady;
    logic [OP_W-1:0]      ShiftSelect;
    logic [AMT_W-1:0]     ShifterAmount;
    logic [WIDTH-1:0]     OriginA;
    logic [WIDTH-1:0]     OriginB;
    logic [ADDR_W-1:0]    DestAddr;
    logic                 IllegalOp;
    logic [7:0]           IllegalCount;

    modport slave (
        input  InstrValid, Instr, WriteEnable, WriteAddr, WriteData, OutReady,
        output InstrReady, OutValid, ShiftSelect, ShifterAmount, OriginA, OriginB,
               DestAddr, IllegalOp, IllegalCount
    );

    modport master (
        output InstrValid, Instr, WriteEnable, WriteAddr, WriteData, OutReady,
        input  InstrReady, OutValid, ShiftSelect, ShifterAmount, OriginA, OriginB,
               DestAddr, IllegalOp, IllegalCount
    );

endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 8x16 register file, two bypassing read ports, R0 hardwired to zero
module register_file
    import datapath_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadAddrA,
    input  logic [ADDR_W-1:0] ReadAddrB,
    output logic [WIDTH-1:0]  ReadDataA,
    output logic [WIDTH-1:0]  ReadDataB
);

    logic [WIDTH-1:0] mem [REGS];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < REGS; i++) mem[i] <= '0;
        end else if (WriteEnable && WriteAddr != '0) begin
            mem[WriteAddr] <= WriteData;
        end
    end

    // A same-cycle write to the addressed register wins over the stale entry.
    always_comb begin
        ReadDataA = mem[ReadAddrA];
        ReadDataB = mem[ReadAddrB];
        if (WriteEnable && WriteAddr != '0 && WriteAddr == ReadAddrA) ReadDataA = WriteData;
        if (WriteEnable && WriteAddr != '0 && WriteAddr == ReadAddrB) ReadDataB = WriteData;
        if (ReadAddrA == '0) ReadDataA = '0;
        if (ReadAddrB == '0) ReadDataB = '0;
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode, operand read and single-slot handoff to the barrel shifter
module operand_fetch
    import datapath_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    operand_fetch_if.slave bus
);

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd, ra, rb;
    logic [AMT_W-1:0]  amt;
    logic [WIDTH-1:0]  readA, readB;
    logic              instrReady, accept, legal;

    logic              outValidQ, illegalOpQ;
    logic [OP_W-1:0]   shiftSelectQ;
    logic [AMT_W-1:0]  shifterAmountQ;
    logic [WIDTH-1:0]  originAQ, originBQ;
    logic [ADDR_W-1:0] destAddrQ;
    logic [7:0]        illegalCountQ;

    assign op  = bus.Instr[OP_LSB  +: OP_W];
    assign rd  = bus.Instr[RD_LSB  +: ADDR_W];
    assign ra  = bus.Instr[RA_LSB  +: ADDR_W];
    assign rb  = bus.Instr[RB_LSB  +: ADDR_W];
    assign amt = bus.Instr[AMT_LSB +: AMT_W];

    register_file uRegFile (
        .Clk        (Clk),
        .Reset      (Reset),
        .WriteEnable(bus.WriteEnable),
        .WriteAddr  (bus.WriteAddr),
        .WriteData  (bus.WriteData),
        .ReadAddrA  (ra),
        .ReadAddrB  (rb),
        .ReadDataA  (readA),
        .ReadDataB  (readB)
    );

    // The slot frees up in the same cycle it drains, giving full throughput.
    assign instrReady = !outValidQ || bus.OutReady;
    assign accept     = bus.InstrValid && instrReady;
    assign legal      = isLegalOp(op);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            outValidQ      <= 1'b0;
            illegalOpQ     <= 1'b0;
            illegalCountQ  <= '0;
            shiftSelectQ   <= '0;
            shifterAmountQ <= '0;
            originAQ       <= '0;
            originBQ       <= '0;
            destAddrQ      <= '0;
        end else begin
            illegalOpQ <= accept && !legal;
            if (accept && !legal && illegalCountQ != 8'hFF)
                illegalCountQ <= illegalCountQ + 8'd1;
            if (accept && legal) begin
                outValidQ      <= 1'b1;
                shiftSelectQ   <= op;
                shifterAmountQ <= amt;
                originAQ       <= readA;
                originBQ       <= readB;
                destAddrQ      <= rd;
            end else if (bus.OutReady) begin
                outValidQ <= 1'b0;
            end
        end
    end

    assign bus.InstrReady    = instrReady;
    assign bus.OutValid      = outValidQ;
    assign bus.ShiftSelect   = shiftSelectQ;
    assign bus.ShifterAmount = shifterAmountQ;
    assign bus.OriginA       = originAQ;
    assign bus.OriginB       = originBQ;
    assign bus.DestAddr      = destAddrQ;
    assign bus.IllegalOp     = illegalOpQ;
    assign bus.IllegalCount  = illegalCountQ;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;
    import datapath_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    always #5 Clk = ~Clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [3:0] amt);
        return {op, rd, ra, rb, amt};
    endfunction

    initial begin
        bus.InstrValid  = 1'b0;
        bus.Instr       = '0;
        bus.WriteEnable = 1'b0;
        bus.WriteAddr   = '0;
        bus.WriteData   = '0;
        bus.OutReady    = 1'b1;

        #2 Reset = 1'b1;
        step();
        check("rst_outvalid", 32'(bus.OutValid), 32'd0);
        check("rst_instrready", 32'(bus.InstrReady), 32'd1);
        check("rst_illcount", 32'(bus.IllegalCount), 32'd0);
        check("rst_origina", 32'(bus.OriginA), 32'd0);
        Reset = 1'b0;

        // Populate R3 and R5
        bus.WriteEnable = 1'b1; bus.WriteAddr = 3'd3; bus.WriteData = 16'hA5A5;
        step();
        bus.WriteAddr = 3'd5; bus.WriteData = 16'h00FF;
        step();
        bus.WriteEnable = 1'b0;

        bus.InstrValid = 1'b1; bus.Instr = mk(3'b010, 3'd1, 3'd3, 3'd5, 4'd4);
        step();
        bus.InstrValid = 1'b0;
        check("basic_outvalid", 32'(bus.OutValid), 32'd1);
        check("basic_sel", 32'(bus.ShiftSelect), 32'h2);
        check("basic_amt", 32'(bus.ShifterAmount), 32'h4);
        check("basic_a", 32'(bus.OriginA), 32'hA5A5);
        check("basic_b", 32'(bus.OriginB), 32'h00FF);
        check("basic_dest", 32'(bus.DestAddr), 32'h1);
        check("basic_illop", 32'(bus.IllegalOp), 32'd0);
        step();
        check("drain_outvalid", 32'(bus.OutValid), 32'd0);

        // Same-cycle write-back bypass
        bus.WriteEnable = 1'b1; bus.WriteAddr = 3'd5; bus.WriteData = 16'h1234;
        bus.InstrValid = 1'b1; bus.Instr = mk(3'b000, 3'd2, 3'd3, 3'd5, 4'd1);
        step();
        check("bypass_b", 32'(bus.OriginB), 32'h1234);
        check("bypass_a_stale_ok", 32'(bus.OriginA), 32'hA5A5);

        bus.WriteAddr = 3'd6; bus.WriteData = 16'hBEEF;
        bus.Instr = mk(3'b001, 3'd4, 3'd6, 3'd6, 4'd2);
        step();
        check("bypass_ab_a", 32'(bus.OriginA), 32'hBEEF);
        check("bypass_ab_b", 32'(bus.OriginB), 32'hBEEF);
        check("bypass_ab_sel", 32'(bus.ShiftSelect), 32'h1);

        bus.WriteAddr = 3'd0; bus.WriteData = 16'hFFFF;
        bus.Instr = mk(3'b100, 3'd3, 3'd0, 3'd5, 4'd3);
        step();
        check("r0_bypass_a", 32'(bus.OriginA), 32'h0);
        check("r0_prev_write_b", 32'(bus.OriginB), 32'h1234);
        bus.WriteEnable = 1'b0;
        step();
        check("r0_after_write_a", 32'(bus.OriginA), 32'h0);
        bus.InstrValid = 1'b0;
        step();

        // Backpressure: slot frozen, competing input and write-back ignored by slot
        bus.OutReady = 1'b0;
        bus.InstrValid = 1'b1; bus.Instr = mk(3'b011, 3'd7, 3'd3, 3'd5, 4'd15);
        step();
        check("stall_load_valid", 32'(bus.OutValid), 32'd1);
        bus.Instr = mk(3'b000, 3'd2, 3'd5, 3'd3, 4'd0);
        bus.WriteEnable = 1'b1; bus.WriteAddr = 3'd3; bus.WriteData = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(bus.InstrReady), 32'd0);
            step();
            check("stall_valid", 32'(bus.OutValid), 32'd1);
            check("stall_sel", 32'(bus.ShiftSelect), 32'h3);
            check("stall_amt", 32'(bus.ShifterAmount), 32'hF);
            check("stall_a", 32'(bus.OriginA), 32'hA5A5);
            check("stall_dest", 32'(bus.DestAddr), 32'h7);
        end
        bus.WriteEnable = 1'b0;

        bus.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.Instr = mk(3'(i), 3'(i + 1), 3'd3, 3'd5, 4'(i + 8));
            #1;
            check("b2b_ready", 32'(bus.InstrReady), 32'd1);
            step();
            check("b2b_valid", 32'(bus.OutValid), 32'd1);
            check("b2b_sel", 32'(bus.ShiftSelect), 32'(i));
            check("b2b_amt", 32'(bus.ShifterAmount), 32'(i + 8));
            check("b2b_a", 32'(bus.OriginA), 32'h1111);
            check("b2b_dest", 32'(bus.DestAddr), 32'(i + 1));
        end
        bus.InstrValid = 1'b0;
        step();
        check("b2b_drain", 32'(bus.OutValid), 32'd0);

        // Illegal op consumed and counted
        bus.InstrValid = 1'b1; bus.Instr = mk(3'b110, 3'd1, 3'd3, 3'd5, 4'd1);
        step();
        bus.InstrValid = 1'b0;
        check("ill_outvalid", 32'(bus.OutValid), 32'd0);
        check("ill_pulse", 32'(bus.IllegalOp), 32'd1);
        check("ill_count1", 32'(bus.IllegalCount), 32'd1);
        step();
        check("ill_pulse_end", 32'(bus.IllegalOp), 32'd0);
        check("ill_count_hold", 32'(bus.IllegalCount), 32'd1);

        bus.InstrValid = 1'b1; bus.Instr = mk(3'b001, 3'd2, 3'd3, 3'd5, 4'd1);
        step();
        check("drain_ill_pre", 32'(bus.OutValid), 32'd1);
        bus.Instr = mk(3'b101, 3'd2, 3'd3, 3'd5, 4'd1);
        step();
        check("drain_ill_valid", 32'(bus.OutValid), 32'd0);
        check("drain_ill_pulse", 32'(bus.IllegalOp), 32'd1);
        check("drain_ill_count", 32'(bus.IllegalCount), 32'd2);

        bus.Instr = mk(3'b111, 3'd0, 3'd0, 3'd0, 4'd0);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 251) check("sat_count_254", 32'(bus.IllegalCount), 32'd254);
        end
        check("sat_count_255", 32'(bus.IllegalCount), 32'd255);
        check("sat_pulse_held", 32'(bus.IllegalOp), 32'd1);
        bus.InstrValid = 1'b0;
        step();

        // Asynchronous reset while a stalled slot is held
        bus.OutReady = 1'b0;
        bus.InstrValid = 1'b1; bus.Instr = mk(3'b100, 3'd5, 3'd3, 3'd5, 4'd7);
        step();
        bus.InstrValid = 1'b0;
        check("prerst_valid", 32'(bus.OutValid), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.OutValid), 32'd0);
        check("async_rst_count", 32'(bus.IllegalCount), 32'd0);
        check("async_rst_a", 32'(bus.OriginA), 32'd0);
        check("async_rst_sel", 32'(bus.ShiftSelect), 32'd0);
        #1 Reset = 1'b0;
        bus.OutReady = 1'b1;
        bus.InstrValid = 1'b1; bus.Instr = mk(3'b000, 3'd1, 3'd3, 3'd5, 4'd0);
        step();
        check("postrst_r3", 32'(bus.OriginA), 32'd0);
        check("postrst_r5", 32'(bus.OriginB), 32'd0);
        bus.Instr = mk(3'b000, 3'd1, 3'd6, 3'd6, 4'd0);
        step();
        bus.InstrValid = 1'b0;
        check("postrst_r6", 32'(bus.OriginA), 32'd0);
        check("postrst_count", 32'(bus.IllegalCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage directly upstream of the 16-bit barrel shifter. Decodes a 16-bit instruction word, reads two operands from an 8-entry register file (with write-back bypass), and presents ShiftSelect, ShifterAmount, OriginB (plus OriginA and destination) from a single registered output slot under a valid/ready handshake. Illegal shift opcodes are consumed and counted, never forwarded.

## Interface
- WIDTH, 16, datapath width
- REGS, 8, register-file entries (address width 3)
- AMT_W, 4, shift-amount width
- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- InstrValid  in  1  instruction word valid
- Instr  in  16  [15:13] op, [12:10] Rd, [9:7] Ra, [6:4] Rb, [3:0] amount
- InstrReady  out  1  stage can accept an instruction this cycle
- WriteEnable  in  1  write-back strobe
- WriteAddr  in  3  write-back register index
- WriteData  in  WIDTH  write-back value
- OutValid  out  1  output slot holds a decoded instruction
- OutReady  in  1  shifter stage accepts the slot
- ShiftSelect  out  3  op field, only 000..100 ever driven valid
- ShifterAmount  out  AMT_W  amount field
- OriginA  out  WIDTH  value of Ra
- OriginB  out  WIDTH  value of Rb
- DestAddr  out  3  Rd
- IllegalOp  out  1  one-cycle pulse when an illegal op is consumed
- IllegalCount  out  8  saturating count of illegal ops

## Operation
- Legal ops: 000 logical right, 001 logical left, 010 rotate right, 011 rotate left, 100 arithmetic right; 101..111 illegal.
- Register file: 8×16, all entries 0 after reset. R0 reads 0 always; writes to R0 ignored.
- Write: WriteEnable at a rising edge updates WriteAddr (if nonzero) at that edge.
- Read with bypass: if WriteEnable && WriteAddr==Ra && WriteAddr!=0 in the accept cycle, OriginA captures WriteData, not stale entry; same rule for Rb. Ra==Rb both bypass.
- InstrReady = !OutValid || OutReady (combinational; never depends on InstrValid).
- Accept = InstrValid && InstrReady.
- Accept, legal op: slot loads all output fields; OutValid=1 next cycle.
- Accept, illegal op: instruction consumed, slot not loaded; IllegalOp=1 for next cycle only; IllegalCount += 1, holds at 255.
- Slot drains when OutValid && OutReady; if no legal accept same cycle, OutValid=0 next cycle. Drain + legal accept same cycle: slot reloads, OutValid stays 1 (back-to-back, full throughput).
- Drain + illegal accept same cycle: OutValid=0 next cycle, IllegalOp pulses.
- Output fields stable while OutValid && !OutReady (stall); input ignored (InstrReady=0).
- Write-back during stall updates the register file but not the held slot.

## Timing
- Reset (async, any time): OutValid=0, IllegalOp=0, IllegalCount=0, ShiftSelect/ShifterAmount/OriginA/OriginB/DestAddr=0, register file cleared; takes effect without clock edge. An in-flight slot is discarded.
- First accept possible on first rising edge after Reset deasserts (InstrReady=1 out of reset).
- Latency: accept edge N → OutValid and fields visible after edge N (one cycle).
- Bypass window is exactly the accept cycle; a write one cycle earlier is already in the array.
- IllegalOp asserted exactly one cycle per illegal accept; consecutive illegal accepts keep it high.

## Structure
- Shared package datapath_pkg: op constants (OP_SRL=3'b000, OP_SLL, OP_ROR, OP_ROL, OP_SRA), instruction field bit positions, WIDTH/address-width constants; barrel shifter and this block both import it.
- One sub-module: register_file (8×16, two combinational read ports with bypass, one write port, async reset clear, R0 hardwired zero). Handshake, decode, slot register and counter stay in operand_fetch.

## Test plan
- Write R3=16'hA5A5, R5=16'h00FF; then Instr op=010,Rd=1,Ra=3,Rb=5,amt=4 with OutReady=1 → next cycle OutValid=1, ShiftSelect=010, ShifterAmount=4, OriginA=A5A5, OriginB=00FF, DestAddr=1.
- Bypass: same cycle WriteEnable R5=16'h1234 and accept Rb=5 → OriginB=1234; write to R0=FFFF then read Ra=0 → OriginA=0000.
- Backpressure: OutReady=0 for 3 cycles after a legal accept → fields frozen, InstrReady=0; OutReady=1 with new legal Instr → slot reloads, OutValid stays 1, one output per cycle for 4 back-to-back instructions.
- Illegal op 110 accepted → no OutValid, IllegalOp one-cycle pulse, IllegalCount=1; 300 illegal ops → IllegalCount=255.
- Reset asserted mid-cycle while OutValid=1 and stalled → OutValid=0 immediately, all registers read 0 after release, IllegalCount=0.
